lbus_initiator: RTL and testbench
=================================

// Module: lbus_initiator
// PURPOSE
//  Local-bus master that drives SURF-side target cycles (nADS/WnR/LA/LD/nCS2/nCS3/nRD, completed by nREADY).
//  Converts a single-beat request/response interface into one bus transaction per request.
//  Used in the board-level bench and in the bridge FPGA that talks to SURF register, HK and LAB spaces.
// PARAMETERS
//  TIMEOUT_CYCLES  256  DATA-phase cycles waited for nREADY before error (used only with LBUS_TIMEOUT_EN)
// PORTS
//  clk_i         in    1   single clock; bus outputs change on posedge
//  rst_i         in    1   synchronous reset, active-high
//  req_valid_i   in    1   request present
//  req_ready_o   out   1   initiator idle; request accepted when valid&&ready
//  req_wr_i      in    1   1=write, 0=read
//  req_space_i   in    2   0=REG (nCS2=nCS3=1), 1=HK (nCS2=0), 2=LAB (nCS3=0), 3=reserved
//  req_addr_i    in    6   word address -> LA[7:2]
//  req_wdata_i   in    32  write data
//  rsp_valid_o   out   1   one-cycle pulse: transaction finished
//  rsp_rdata_o   out   32  read data, held until next rsp_valid_o
//  rsp_err_o     out   1   qualified by rsp_valid_o: reserved space or timeout
//  nADS          out   1   address strobe, active low
//  WnR           out   1   1=write cycle
//  LA            out   6   LA[7:2]
//  LD            inout 32  data bus; driven only during write ADDR/DATA phases
//  nCS2          out   1   HK chip select, active low
//  nCS3          out   1   LAB chip select, active low
//  nRD           out   1   read strobe, active low
//  nREADY        in    1   target ready, active low
// BEHAVIOUR
//  Reset: req_ready_o=0 during reset, 1 after; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0; nADS=nCS2=nCS3=nRD=1, WnR=0, LA=0; LD tri-stated.
//  FSM states: IDLE, ADDR, DATA, TURN, ERR.
//  IDLE: req_ready_o=1; on accept register wr/space/addr/wdata; space 3 -> ERR, else -> ADDR.
//  ADDR (1 cycle): nADS=0, LA, WnR, chip select asserted; write: LD driven with wdata. nREADY ignored. -> DATA.
//  DATA: nADS=1; CS, LA, WnR held; read: nRD=0; write: LD held. On posedge with nREADY=0:
//   capture LD into rsp_rdata_o (reads only), pulse rsp_valid_o (err=0), -> TURN.
//  TURN (1 cycle): CS, nRD deasserted; LD released; -> IDLE. Guarantees one idle bus cycle between transactions.
//  ERR (1 cycle): no bus activity; rsp_valid_o=1, rsp_err_o=1; -> IDLE.
//  Minimum latency accept->rsp_valid_o: 2 cycles (zero wait states). Minimum issue rate: 1 transaction per 4 cycles.
//  Writes leave rsp_rdata_o unchanged.
//  req_valid_i outside IDLE: ignored (req_ready_o=0); requester holds it.
//  rst_i mid-transaction: all bus outputs revert to reset values on that edge; no rsp_valid_o for the aborted request.
// CONFIGURATION
//  LBUS_TIMEOUT_EN defined: wait counter cleared in ADDR and incremented each DATA cycle with nREADY=1;
//   at TIMEOUT_CYCLES -> rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o unchanged, -> TURN.
//  Not defined: DATA waits indefinitely for nREADY; rsp_err_o asserts only for reserved space.
// STRUCTURE
//  Package lbus_pkg: space codes (LBUS_SPACE_REG/HK/LAB/RSVD), FSM state encodings, default TIMEOUT_CYCLES.
//  Sub-module lbus_wait_timer (clear/enable/expired counter), instantiated only under LBUS_TIMEOUT_EN.
//  LD: registered output-enable and output data per bit, tri-state at the pad.
// TESTING
//  Bench: behavioural target model with programmable wait states; register 0 returns 0x53555246.
//  1 Read REG addr 0, zero waits -> nADS low 1 cycle, nRD low, rsp_valid_o 2 cycles after accept, rdata=0x53555246, err=0.
//  2 Write REG addr 6 data 0x00000002 -> WnR=1, LD=0x00000002 in ADDR+DATA, nCS2=nCS3=1, model logs write, err=0.
//  3 Read LAB addr 0 with 5 wait states -> nCS3 low for whole DATA, rsp_valid_o exactly when nREADY low, rdata matches model.
//  4 Back-to-back HK reads with req_valid_i held high -> nADS pulses 4 cycles apart, LD undriven by initiator throughout.
//  5 Space 3 request -> no nADS, rsp_valid_o and rsp_err_o 1 cycle after accept; LBUS_TIMEOUT_EN with nREADY stuck high -> err after 256 DATA cycles.
//  6 rst_i asserted in DATA mid-write -> next edge: nADS/nCS/nRD high, LD released, no rsp_valid_o; next request completes normally.

Source files
------------

// File: rtl/lbus_pkg.sv
// lbus_pkg: address-space codes, FSM state encoding and default timeout
// shared by the local-bus initiator and its optional wait timer.
package lbus_pkg;

    localparam int LBUS_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        LBUS_SPACE_REG  = 2'd0,
        LBUS_SPACE_HK   = 2'd1,
        LBUS_SPACE_LAB  = 2'd2,
        LBUS_SPACE_RSVD = 2'd3
    } lbus_space_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_TURN = 3'd3,
        ST_ERR  = 3'd4
    } lbus_state_e;

endpackage

// File: rtl/lbus_wait_timer.sv
// lbus_wait_timer: counts DATA-phase wait cycles and flags when the
// target has held off for LIMIT cycles. Only instantiated when the
// initiator is built with LBUS_TIMEOUT_EN.
module lbus_wait_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Wait counter: cleared per transaction, saturates once expired.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expired during the LIMIT-th waiting cycle so the FSM leaves on that edge.
    assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/lbus_initiator.sv
// lbus_initiator: single-beat request/response to SURF local-bus master.
// One bus transaction per accepted request: ADDR -> DATA (wait for nREADY)
// -> TURN, or a one-cycle ERR response for the reserved space.
// Build option: define LBUS_TIMEOUT_EN to abort DATA after TIMEOUT_CYCLES
// cycles without nREADY (error response, read data left unchanged).
module lbus_initiator
    import lbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LBUS_TIMEOUT_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic [1:0]  req_space_i,
    input  logic [5:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        nADS,
    output logic        WnR,
    output logic [5:0]  LA,
    inout  wire  [31:0] LD,
    output logic        nCS2,
    output logic        nCS3,
    output logic        nRD,
    input  logic        nREADY
);

    lbus_state_e state_q, state_d;
    lbus_space_e space_q;
    logic        wr_q;
    logic [5:0]  addr_q;
    logic        accept;
    logic        wr_nxt;
    logic        timeout;
    logic        bus_act;
    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] ld_oe_q, ld_out_q;

`ifdef LBUS_TIMEOUT_EN
    logic wait_expired;

    lbus_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == ST_ADDR),
        .enable_i ((state_q == ST_DATA) && nREADY),
        .expired_o(wait_expired)
    );

    assign timeout = (state_q == ST_DATA) && nREADY && wait_expired;
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    assign req_ready_o = (state_q == ST_IDLE) && !rst_i;

    // Next-state decode; requests are only looked at while idle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    accept  = 1'b1;
                    state_d = (lbus_space_e'(req_space_i) == LBUS_SPACE_RSVD) ? ST_ERR : ST_ADDR;
                end
            end
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: begin
                if (!nREADY || timeout) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_nxt = accept ? req_wr_i : wr_q;

    // Control state, response flags and LD output enables.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ld_oe_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_q == ST_ERR) || ((state_q == ST_DATA) && (!nREADY || timeout));
            rsp_err_q   <= (state_q == ST_ERR) || timeout;
            if ((state_q == ST_DATA) && !nREADY && !wr_q) begin
                rsp_rdata_q <= LD;
            end
            ld_oe_q <= {32{wr_nxt && ((state_d == ST_ADDR) || (state_d == ST_DATA))}};
        end
    end

    // Request fields captured on accept; held for the whole transaction.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            wr_q     <= req_wr_i;
            space_q  <= lbus_space_e'(req_space_i);
            addr_q   <= req_addr_i;
            ld_out_q <= req_wdata_i;
        end
    end

    assign bus_act = (state_q == ST_ADDR) || (state_q == ST_DATA);

    assign nADS = !(state_q == ST_ADDR);
    assign WnR  = bus_act && wr_q;
    assign LA   = bus_act ? addr_q : 6'd0;
    assign nCS2 = !(bus_act && (space_q == LBUS_SPACE_HK));
    assign nCS3 = !(bus_act && (space_q == LBUS_SPACE_LAB));
    assign nRD  = !((state_q == ST_DATA) && !wr_q);

    for (genvar i = 0; i < 32; i++) begin : g_ld_pad
        assign LD[i] = ld_oe_q[i] ? ld_out_q[i] : 1'bz;
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_lbus_initiator.sv
// tb_lbus_initiator: directed and randomized transactions against a
// behavioural SURF target with programmable wait states.
module tb_lbus_initiator;

    localparam int TO_CYC = 256;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_wr_i = 1'b0;
    logic [1:0]  req_space_i = 2'd0;
    logic [5:0]  req_addr_i = 6'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        nADS, WnR, nCS2, nCS3, nRD;
    logic [5:0]  LA;
    wire  [31:0] LD;
    logic        nREADY = 1'b1;

    logic        tgt_oe = 1'b0;
    logic [31:0] tgt_data = 32'd0;
    assign LD = tgt_oe ? tgt_data : 32'hzzzz_zzzz;

    always #5 clk_i = ~clk_i;

    lbus_initiator dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_wr_i(req_wr_i), .req_space_i(req_space_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .nADS(nADS), .WnR(WnR), .LA(LA), .LD(LD),
        .nCS2(nCS2), .nCS3(nCS3), .nRD(nRD), .nREADY(nREADY)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] tgt_mem [0:2][0:63];
    logic [31:0] ref_mem [0:2][0:63];
    logic [31:0] last_rdata = 32'd0;
    logic [31:0] cur_wdata = 32'd0;
    int          model_waits = 0;

    int          ads_q[$];
    logic [32:0] rsp_q[$];
    int          rsp_cyc_q[$];
    int nrd_low = 0, cs2_low = 0, cs3_low = 0, wnr_high = 0, ld_bad = 0, wr_ld_bad = 0;

    int          t_phase = 0, t_cnt = 0, t_sp = 0;
    logic        t_wr = 1'b0;
    logic [5:0]  t_addr = 6'd0;

    int          acc[3];
    int          k, ldb0, rc;
    logic [32:0] r;
    logic        rw;
    logic [1:0]  rs;
    logic [5:0]  ra;
    logic [31:0] rd;
    int          rws;

    function automatic logic [31:0] init_val(int s, int a);
        if (s == 0 && a == 0) return 32'h5355_5246;
        return 32'h1000_0000 * s + 32'h0001_0101 * a + 32'h00C0_0000;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Bus monitor: sampled on the falling edge, away from DUT updates.
    always @(negedge clk_i) begin
        if (!nADS) ads_q.push_back(cyc);
        if (rsp_valid_o) begin
            rsp_q.push_back({rsp_err_o, rsp_rdata_o});
            rsp_cyc_q.push_back(cyc);
        end
        if (!nRD)  nrd_low++;
        if (!nCS2) cs2_low++;
        if (!nCS3) cs3_low++;
        if (WnR)   wnr_high++;
        if (!tgt_oe && !WnR && !(LD === 32'hzzzz_zzzz)) ld_bad++;
        if (WnR && LD !== cur_wdata) wr_ld_bad++;
    end

    // Target model: decodes space from chip selects, inserts wait states.
    always begin
        @(negedge clk_i);
        #2;
        if (rst_i) begin
            t_phase = 0; tgt_oe = 1'b0; nREADY = 1'b1;
        end else begin
            case (t_phase)
                0: begin
                    nREADY = 1'b1; tgt_oe = 1'b0;
                    if (!nADS) begin
                        t_wr = WnR; t_addr = LA; t_cnt = model_waits;
                        t_sp = !nCS2 ? 1 : (!nCS3 ? 2 : 0);
                        t_phase = 1;
                    end
                end
                1: begin
                    if (!WnR && nRD) begin
                        t_phase = 0; nREADY = 1'b1; tgt_oe = 1'b0;
                    end else if (t_cnt == 0) begin
                        nREADY = 1'b0;
                        if (t_wr) begin
                            if (!(t_sp == 0 && t_addr == 6'd0)) tgt_mem[t_sp][t_addr] = LD;
                        end else begin
                            tgt_data = tgt_mem[t_sp][t_addr];
                            tgt_oe = 1'b1;
                        end
                        t_phase = 2;
                    end else begin
                        t_cnt--;
                    end
                end
                default: begin
                    nREADY = 1'b1; tgt_oe = 1'b0; t_phase = 0;
                end
            endcase
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic wr, input logic [1:0] sp, input logic [5:0] ad,
                       input logic [31:0] wd, input int waits, input string tag);
        int kk, acc_cyc, rcyc, dcyc;
        int nrd0, cs20, cs30, wnr0, ldb, wlb0;
        logic rsvd, tmo, exp_err;
        logic [31:0] exp_rd;
        logic [32:0] rr;
        rsvd = (sp == 2'd3);
        tmo  = 1'b0;
`ifdef LBUS_TIMEOUT_EN
        tmo = !rsvd && (waits >= TO_CYC);
`endif
        exp_err = rsvd || tmo;
        dcyc    = tmo ? TO_CYC : waits + 1;
        exp_rd  = last_rdata;
        if (!exp_err && !wr) exp_rd = ref_mem[sp][ad];

        model_waits = waits; cur_wdata = wd;
        nrd0 = nrd_low; cs20 = cs2_low; cs30 = cs3_low; wnr0 = wnr_high; ldb = ld_bad; wlb0 = wr_ld_bad;
        ads_q.delete(); rsp_q.delete(); rsp_cyc_q.delete();

        req_valid_i = 1'b1; req_wr_i = wr; req_space_i = sp; req_addr_i = ad; req_wdata_i = wd;
        kk = 0;
        while (!req_ready_o && kk < 20) begin step(); kk++; end
        check({tag, "_accept"}, req_ready_o, 1);
        acc_cyc = cyc + 1;
        step();
        req_valid_i = 1'b0;
        kk = 0;
        while (rsp_q.size() == 0 && kk < 600) begin step(); kk++; end
        check({tag, "_rsp_seen"}, rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
            rr   = rsp_q.pop_front();
            rcyc = rsp_cyc_q.pop_front();
            check({tag, "_latency"}, rcyc - acc_cyc, rsvd ? 1 : 1 + dcyc);
            check({tag, "_err"}, rr[32], exp_err);
            check({tag, "_rdata"}, rr[31:0], exp_rd);
        end
        step(); step();
        check({tag, "_single_pulse"}, rsp_q.size(), 0);
        check({tag, "_nads_count"}, ads_q.size(), rsvd ? 0 : 1);
        if (!rsvd && ads_q.size() != 0) check({tag, "_nads_cycle"}, ads_q[0], acc_cyc);
        check({tag, "_nrd_cycles"}, nrd_low - nrd0, (!wr && !rsvd) ? dcyc : 0);
        check({tag, "_ncs2_cycles"}, cs2_low - cs20, (sp == 2'd1) ? 1 + dcyc : 0);
        check({tag, "_ncs3_cycles"}, cs3_low - cs30, (sp == 2'd2) ? 1 + dcyc : 0);
        check({tag, "_wnr_cycles"}, wnr_high - wnr0, (wr && !rsvd) ? 1 + dcyc : 0);
        check({tag, "_ld_release"}, ld_bad - ldb, 0);
        check({tag, "_ld_wdata"}, wr_ld_bad - wlb0, 0);
        if (!exp_err && wr) begin
            if (!(sp == 2'd0 && ad == 6'd0)) ref_mem[sp][ad] = wd;
            check({tag, "_target_wrote"}, tgt_mem[sp][ad], ref_mem[sp][ad]);
        end
        if (!exp_err && !wr) last_rdata = exp_rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            for (int a = 0; a < 64; a++) begin
                tgt_mem[s][a] = init_val(s, a);
                ref_mem[s][a] = init_val(s, a);
            end
        end

        repeat (3) step();
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        check("rst_nads", nADS, 1);
        check("rst_ncs2", nCS2, 1);
        check("rst_ncs3", nCS3, 1);
        check("rst_nrd", nRD, 1);
        check("rst_wnr", WnR, 0);
        check("rst_la", LA, 0);
        check("rst_ld_z", LD === 32'hzzzz_zzzz, 1);
        rst_i = 1'b0;
        step();
        check("post_rst_req_ready", req_ready_o, 1);

        txn(1'b0, 2'd0, 6'd0, 32'd0, 0, "t1_rd_reg0");
        txn(1'b1, 2'd0, 6'd6, 32'h0000_0002, 0, "t2_wr_reg6");
        txn(1'b0, 2'd2, 6'd0, 32'd0, 5, "t3_rd_lab_w5");

        model_waits = 0;
        ads_q.delete(); rsp_q.delete(); rsp_cyc_q.delete();
        ldb0 = ld_bad;
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_space_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            req_addr_i = 6'(i + 1);
            k = 0;
            while (!req_ready_o && k < 20) begin step(); k++; end
            acc[i] = cyc + 1;
            step();
        end
        req_valid_i = 1'b0;
        k = 0;
        while (rsp_q.size() < 3 && k < 50) begin step(); k++; end
        step(); step();
        check("t4_rsp_count", rsp_q.size(), 3);
        check("t4_nads_count", ads_q.size(), 3);
        if (ads_q.size() == 3) begin
            check("t4_nads_gap01", ads_q[1] - ads_q[0], 4);
            check("t4_nads_gap12", ads_q[2] - ads_q[1], 4);
        end
        for (int i = 0; i < 3; i++) begin
            if (rsp_q.size() != 0) begin
                r  = rsp_q.pop_front();
                rc = rsp_cyc_q.pop_front();
                check("t4_rdata", r[31:0], ref_mem[1][i + 1]);
                check("t4_err", r[32], 0);
                check("t4_latency", rc - acc[i], 2);
            end
        end
        last_rdata = ref_mem[1][3];
        check("t4_ld_undriven", ld_bad - ldb0, 0);

        txn(1'b0, 2'd3, 6'd5, 32'd0, 0, "t5_rsvd_rd");
        txn(1'b1, 2'd3, 6'd7, 32'h0000_1234, 0, "t5_rsvd_wr");
`ifdef LBUS_TIMEOUT_EN
        txn(1'b0, 2'd1, 6'd3, 32'd0, 300, "t5_timeout");
`endif

        model_waits = 20; cur_wdata = 32'hDEAD_BEEF;
        rsp_q.delete(); rsp_cyc_q.delete();
        req_valid_i = 1'b1; req_wr_i = 1'b1; req_space_i = 2'd0;
        req_addr_i = 6'd6; req_wdata_i = 32'hDEAD_BEEF;
        k = 0;
        while (!req_ready_o && k < 20) begin step(); k++; end
        step();
        req_valid_i = 1'b0;
        step(); step();
        check("t6_mid_write_wnr", WnR, 1);
        rst_i = 1'b1;
        step();
        check("t6_nads", nADS, 1);
        check("t6_ncs2", nCS2, 1);
        check("t6_ncs3", nCS3, 1);
        check("t6_nrd", nRD, 1);
        check("t6_wnr", WnR, 0);
        check("t6_ld_z", LD === 32'hzzzz_zzzz, 1);
        check("t6_rsp_valid", rsp_valid_o, 0);
        check("t6_req_ready", req_ready_o, 0);
        rst_i = 1'b0;
        step(); step(); step();
        check("t6_no_rsp", rsp_q.size(), 0);
        check("t6_target_untouched", tgt_mem[0][6], ref_mem[0][6]);
        check("t6_rdata_cleared", rsp_rdata_o, 0);
        last_rdata = 32'd0;
        txn(1'b0, 2'd0, 6'd6, 32'd0, 1, "t6_after_reset_rd");

        for (int n = 0; n < 24; n++) begin
            rw  = 1'($urandom_range(0, 1));
            rs  = 2'($urandom_range(0, 3));
            ra  = 6'($urandom_range(0, 63));
            rd  = $urandom;
            rws = $urandom_range(0, 4);
            txn(rw, rs, ra, rd, rws, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
